// File: rtl/adiv5_mem_sequencer_if.sv
// ---------------------------------------------------------------------------
// adiv5_mem_sequencer_if
//   Bundles every non-clock signal of adiv5_mem_sequencer.
//   Request side  : REQ_VALID/READY/WRITE/SIZE/APSEL/ADDR/WDATA, CACHE_INV
//   Completion    : RSP_VALID, RSP_RDATA, RSP_STAT
//   Command FIFO  : CMD_DATA, CMD_WREN, CMD_FULL
//   Response FIFO : RSP_RDDATA, RSP_RDEN, RSP_EMPTY
//   slave  modport: the sequencer itself
//   master modport: the surroundings (bridge front end plus engine FIFOs)
// ---------------------------------------------------------------------------
interface adiv5_mem_sequencer_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WRITE;
  logic [1:0]  REQ_SIZE;
  logic [7:0]  REQ_APSEL;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic [2:0]  RSP_STAT;
  logic        CACHE_INV;
  logic [39:0] CMD_DATA;
  logic        CMD_WREN;
  logic        CMD_FULL;
  logic [34:0] RSP_RDDATA;
  logic        RSP_RDEN;
  logic        RSP_EMPTY;

  modport slave (
    input  REQ_VALID, REQ_WRITE, REQ_SIZE, REQ_APSEL, REQ_ADDR, REQ_WDATA,
    input  CACHE_INV, CMD_FULL, RSP_RDDATA, RSP_EMPTY,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_STAT, CMD_DATA, CMD_WREN, RSP_RDEN
  );

  modport master (
    output REQ_VALID, REQ_WRITE, REQ_SIZE, REQ_APSEL, REQ_ADDR, REQ_WDATA,
    output CACHE_INV, CMD_FULL, RSP_RDDATA, RSP_EMPTY,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_STAT, CMD_DATA, CMD_WREN, RSP_RDEN
  );
endinterface

// File: rtl/adiv5_mem_sequencer.sv
// ---------------------------------------------------------------------------
// adiv5_mem_sequencer
//   Turns one 8/16/32-bit memory request into the ADIv5 command sequence
//   SELECT, CSW, TAR, DRW, RDBUFF, pushes it into the engine's 40-bit command
//   FIFO and collects the single RDBUFF response from the 35-bit response FIFO.
//   SELECT and CSW are cached so repeated accesses only issue TAR/DRW/RDBUFF.
// Ports:
//   CLK    : clock
//   RESETn : asynchronous active-low reset
//   bus    : adiv5_mem_sequencer_if.slave (request, completion, command FIFO
//            push side, response FIFO pop side, cache invalidate)
// Parameters:
//   CSW_BASE : CSW value with SIZE=0 and AddrInc=00; the access size is ORed in
//   TIMEOUT  : WAIT cycles before giving up with status 3'b111 (>= 2)
// ---------------------------------------------------------------------------
module adiv5_mem_sequencer #(
  parameter logic [31:0] CSW_BASE = 32'hA2000000,
  parameter int unsigned TIMEOUT  = 1024
) (
  input logic                  CLK,
  input logic                  RESETn,
  adiv5_mem_sequencer_if.slave bus
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_CSW, S_TAR, S_DRW, S_RDBUF, S_WAIT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic             req_write;
  logic [1:0]       req_size;
  logic [7:0]       req_apsel;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic             sel_valid;
  logic [7:0]       sel_apsel;
  logic             csw_valid;
  logic [1:0]       csw_size;
  logic [CNT_W-1:0] to_cnt;
  logic             rd_pending;
  logic [3:0]       stale_cnt;
  logic [31:0]      rsp_rdata;
  logic [2:0]       rsp_stat;

  logic             sel_skip;
  logic             csw_skip;
  logic             need_push;
  logic             push_fire;
  logic             rsp_take;
  logic             timed_out;
  logic [39:0]      cmd_word;

  function automatic logic [39:0] pack_cmd(input logic [31:0] data, input logic [5:0] idx,
                                           input logic apndp, input logic rnw);
    return {data, idx, apndp, rnw};
  endfunction

  // Sub-word writes replicate the data across all byte lanes so the MEM-AP
  // picks the right lane regardless of the low address bits.
  function automatic logic [31:0] lane_rep(input logic [31:0] d, input logic [1:0] size);
    case (size)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] size,
                                          input logic [1:0] off);
    case (size)
      2'd0:    return {24'h0, d[{off, 3'b000} +: 8]};
      2'd1:    return {16'h0, d[{off[1], 4'b0000} +: 16]};
      default: return d;
    endcase
  endfunction

  // A same-cycle CACHE_INV defeats the skip so the write is always reissued.
  assign sel_skip  = sel_valid && (sel_apsel == req_apsel) && !bus.CACHE_INV;
  assign csw_skip  = csw_valid && (csw_size == req_size) && !bus.CACHE_INV;
  // Responses owed by earlier timed-out transactions are popped and dropped.
  assign rsp_take  = rd_pending && (stale_cnt == 4'd0);
  assign timed_out = !rd_pending && bus.RSP_EMPTY && (to_cnt >= CNT_LAST);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.REQ_VALID)          state_nxt = S_SEL;
      S_SEL:   if (sel_skip || push_fire)  state_nxt = S_CSW;
      S_CSW:   if (csw_skip || push_fire)  state_nxt = S_TAR;
      S_TAR:   if (push_fire)              state_nxt = S_DRW;
      S_DRW:   if (push_fire)              state_nxt = S_RDBUF;
      S_RDBUF: if (push_fire)              state_nxt = S_WAIT;
      S_WAIT:  if (rsp_take || timed_out)  state_nxt = S_DONE;
      S_DONE:                              state_nxt = S_IDLE;
      default:                             state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    need_push = 1'b0;
    cmd_word  = '0;
    case (state)
      S_SEL: if (!sel_skip) begin
        need_push = 1'b1;
        cmd_word  = pack_cmd({req_apsel, 24'h0}, 6'd2, 1'b0, 1'b0);
      end
      S_CSW: if (!csw_skip) begin
        need_push = 1'b1;
        cmd_word  = pack_cmd(CSW_BASE | {30'h0, req_size}, 6'd0, 1'b1, 1'b0);
      end
      S_TAR: begin
        need_push = 1'b1;
        cmd_word  = pack_cmd(req_addr, 6'd1, 1'b1, 1'b0);
      end
      S_DRW: begin
        need_push = 1'b1;
        cmd_word  = req_write ? pack_cmd(lane_rep(req_wdata, req_size), 6'd3, 1'b1, 1'b0)
                              : pack_cmd(32'h0, 6'd3, 1'b1, 1'b1);
      end
      S_RDBUF: begin
        need_push = 1'b1;
        cmd_word  = pack_cmd(32'h0, 6'd3, 1'b0, 1'b1);
      end
      default: ;
    endcase
    push_fire     = need_push && !bus.CMD_FULL;
    bus.CMD_WREN  = push_fire;
    bus.CMD_DATA  = push_fire ? cmd_word : 40'h0;
    // Held low while RESETn is asserted even though the state reads IDLE.
    bus.REQ_READY = (state == S_IDLE) && RESETn;
    // The FIFO has one cycle of read latency: no second pop while one is in flight.
    bus.RSP_RDEN  = (state == S_WAIT) && !rd_pending && !bus.RSP_EMPTY;
    bus.RSP_VALID = (state == S_DONE);
    bus.RSP_RDATA = rsp_rdata;
    bus.RSP_STAT  = rsp_stat;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      req_write  <= 1'b0;
      req_size   <= 2'd0;
      req_apsel  <= 8'h0;
      req_addr   <= 32'h0;
      req_wdata  <= 32'h0;
      sel_valid  <= 1'b0;
      sel_apsel  <= 8'h0;
      csw_valid  <= 1'b0;
      csw_size   <= 2'd0;
      to_cnt     <= '0;
      rd_pending <= 1'b0;
      stale_cnt  <= 4'd0;
      rsp_rdata  <= 32'h0;
      rsp_stat   <= 3'b000;
    end else begin
      if (state == S_IDLE && bus.REQ_VALID) begin
        req_write <= bus.REQ_WRITE;
        req_size  <= (bus.REQ_SIZE == 2'd3) ? 2'd2 : bus.REQ_SIZE;
        req_apsel <= bus.REQ_APSEL;
        req_addr  <= bus.REQ_ADDR;
        req_wdata <= bus.REQ_WDATA;
      end
      if (state == S_SEL && push_fire) begin
        sel_valid <= 1'b1;
        sel_apsel <= req_apsel;
      end
      if (state == S_CSW && push_fire) begin
        csw_valid <= 1'b1;
        csw_size  <= req_size;
      end
      if (state == S_RDBUF && push_fire) begin
        to_cnt     <= '0;
        rd_pending <= 1'b0;
      end
      if (state == S_WAIT) begin
        if (to_cnt < CNT_LAST) to_cnt <= to_cnt + CNT_W'(1);
        rd_pending <= bus.RSP_RDEN;
        if (rd_pending) begin
          if (stale_cnt != 4'd0) begin
            stale_cnt <= stale_cnt - 4'd1;
          end else begin
            rsp_stat  <= bus.RSP_RDDATA[2:0];
            rsp_rdata <= req_write ? 32'h0 : extract(bus.RSP_RDDATA[34:3], req_size, req_addr[1:0]);
            if (bus.RSP_RDDATA[2:0] != 3'b100) begin
              sel_valid <= 1'b0;
              csw_valid <= 1'b0;
            end
          end
        end else if (timed_out) begin
          rsp_stat  <= 3'b111;
          rsp_rdata <= 32'h0;
          sel_valid <= 1'b0;
          csw_valid <= 1'b0;
          if (stale_cnt != 4'hF) stale_cnt <= stale_cnt + 4'd1;
        end
      end
      if (bus.CACHE_INV) begin
        sel_valid <= 1'b0;
        csw_valid <= 1'b0;
      end
    end
  end

endmodule
